// File: rtl/food_placer_pkg.sv
// Shared field bounds, reset food position and FSM state encoding
// for the food placement stage and its body scanner.
package food_placer_pkg;

  localparam logic [9:0] X_MIN = 10'd20;
  localparam logic [9:0] X_MAX = 10'd620;
  localparam logic [9:0] Y_MIN = 10'd20;
  localparam logic [9:0] Y_MAX = 10'd460;

  localparam logic [9:0] FOOD_RST_X = 10'd320;
  localparam logic [9:0] FOOD_RST_Y = 10'd240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SCAN,
    ST_DRAIN,
    ST_COMMIT
  } state_t;

  function automatic logic [9:0] clamp10(
    input logic [9:0] v,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/food_placer_body_scan.sv
// Body memory scanner: sequences read indices, compares the returned
// segment one cycle later, flags hit and last-index-issued (done).
// Ports: i_start loads length, i_step advances, o_rd_idx is registered.
module food_placer_body_scan
  import food_placer_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [IDX_W:0]   i_len,
  input  logic [9:0]       i_cand_x,
  input  logic [9:0]       i_cand_y,
  input  logic [9:0]       i_body_x,
  input  logic [9:0]       i_body_y,
  output logic [IDX_W-1:0] o_rd_idx,
  output logic             o_hit,
  output logic             o_done
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_len;
  logic             r_cmp_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_cmp_v <= 1'b0;
    end else if (i_start) begin
      r_idx   <= '0;
      r_len   <= i_len;
      r_cmp_v <= 1'b0;
    end else if (i_step) begin
      // read data is valid from the second issue cycle on
      r_cmp_v <= 1'b1;
      if (!o_done) r_idx <= r_idx + 1'b1;
    end
  end

  assign o_done   = ({1'b0, r_idx} == (r_len - 1'b1));
  assign o_hit    = r_cmp_v
                 && (i_body_x == i_cand_x)
                 && (i_body_y == i_cand_y);
  assign o_rd_idx = r_idx;

endmodule

// File: rtl/food_placer.sv
// Food placement and eat detection: samples a candidate, rejects body
// collisions, commits food and pulses eat. Optional score: FOOD_SCORE_EN.
// Ports: rand_x/y in, head/move_tick in, body rd port, food/eat/score out.
module food_placer
  import food_placer_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int IDX_W     = 5,
  parameter int MAX_RETRY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       rand_x,
  input  logic [9:0]       rand_y,
  input  logic             restart,
  input  logic             move_tick,
  input  logic [9:0]       head_x,
  input  logic [9:0]       head_y,
  input  logic [IDX_W:0]   snake_len,
  output logic [IDX_W-1:0] body_rd_idx,
  input  logic [9:0]       body_x,
  input  logic [9:0]       body_y,
  output logic [9:0]       food_x,
  output logic [9:0]       food_y,
  output logic             food_valid,
  output logic             eat,
  output logic             place_fail,
  output logic [7:0]       score
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(MAX_LEN);

  state_t        r_state;
  logic [9:0]    r_cand_x;
  logic [9:0]    r_cand_y;
  logic [9:0]    r_food_x;
  logic [9:0]    r_food_y;
  logic          r_food_valid;
  logic          r_eat;
  logic          r_place_fail;
  logic          r_force;
  logic [RW-1:0] r_retry;

  logic          w_legal;
  logic          w_hit;
  logic          w_done;
  logic          w_eat_hit;
  logic          w_scan_start;
  logic          w_scan_step;
  logic          w_reject;
  logic          w_retry_full;
  logic [RW-1:0] w_retry_nx;
  logic [IDX_W:0] w_len;

  assign w_len = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;

  assign w_legal = (rand_x >= X_MIN) && (rand_x <= X_MAX)
                && (rand_y >= Y_MIN) && (rand_y <= Y_MAX);

  assign w_eat_hit = (r_state == ST_IDLE) && move_tick
                  && r_food_valid && !restart
                  && (head_x == r_food_x)
                  && (head_y == r_food_y);

  assign w_scan_start = (r_state == ST_SAMPLE) && w_legal
                     && (w_len != '0) && !restart;

  assign w_scan_step = (r_state == ST_SCAN) && !w_hit;

  assign w_reject = ((r_state == ST_SAMPLE) && !w_legal)
                 || ((r_state == ST_SCAN) && w_hit)
                 || ((r_state == ST_DRAIN) && w_hit);

  assign w_retry_nx = (r_retry >= RETRY_MAX) ? r_retry
                    : r_retry + 1'b1;
  assign w_retry_full = (w_retry_nx >= RETRY_MAX);

  food_placer_body_scan #(
    .IDX_W (IDX_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_scan_start),
    .i_step   (w_scan_step),
    .i_len    (w_len),
    .i_cand_x (r_cand_x),
    .i_cand_y (r_cand_y),
    .i_body_x (body_x),
    .i_body_y (body_y),
    .o_rd_idx (body_rd_idx),
    .o_hit    (w_hit),
    .o_done   (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SAMPLE;
      r_cand_x     <= '0;
      r_cand_y     <= '0;
      r_food_x     <= FOOD_RST_X;
      r_food_y     <= FOOD_RST_Y;
      r_food_valid <= 1'b0;
      r_eat        <= 1'b0;
      r_place_fail <= 1'b0;
      r_force      <= 1'b0;
      r_retry      <= '0;
    end else begin
      r_eat        <= 1'b0;
      r_place_fail <= 1'b0;
      // clamping is identity for legal candidates, so a forced
      // commit after a range rejection lands inside the field
      if (r_state == ST_SAMPLE) begin
        r_cand_x <= clamp10(rand_x, X_MIN, X_MAX);
        r_cand_y <= clamp10(rand_y, Y_MIN, Y_MAX);
      end
      if (restart) begin
        r_food_valid <= 1'b0;
        r_retry      <= '0;
        r_force      <= 1'b0;
        r_state      <= ST_SAMPLE;
      end else if (w_reject) begin
        r_retry <= w_retry_nx;
        if (w_retry_full) begin
          r_force <= 1'b1;
          r_state <= ST_COMMIT;
        end else begin
          r_state <= ST_SAMPLE;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_eat_hit) begin
              r_eat        <= 1'b1;
              r_food_valid <= 1'b0;
              r_retry      <= '0;
              r_state      <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            if (w_len == '0) r_state <= ST_COMMIT;
            else r_state <= ST_SCAN;
          end
          ST_SCAN: begin
            if (w_done) r_state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            r_state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            r_food_x     <= r_cand_x;
            r_food_y     <= r_cand_y;
            r_food_valid <= 1'b1;
            r_retry      <= '0;
            r_place_fail <= r_force;
            r_force      <= 1'b0;
            r_state      <= ST_IDLE;
          end
          default: r_state <= ST_SAMPLE;
        endcase
      end
    end
  end

`ifdef FOOD_SCORE_EN
  logic [7:0] r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
    end else if (restart) begin
      r_score <= '0;
    end else if (w_eat_hit && (r_score != 8'hFF)) begin
      r_score <= r_score + 1'b1;
    end
  end

  assign score = r_score;
`else
  assign score = 8'd0;
`endif

  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign food_valid = r_food_valid;
  assign eat        = r_eat;
  assign place_fail = r_place_fail;

endmodule

// File: tb/tb_food_placer.sv
// Directed self-checking bench for food_placer with a registered
// body memory model (1-cycle read latency).
module tb_food_placer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rand_x, rand_y;
  logic       restart, move_tick;
  logic [9:0] head_x, head_y;
  logic [5:0] snake_len;
  logic [4:0] body_rd_idx;
  logic [9:0] body_x, body_y;
  logic [9:0] food_x, food_y;
  logic       food_valid, eat, place_fail;
  logic [7:0] score;

  logic [9:0] mem_x [32];
  logic [9:0] mem_y [32];

  int n_chk = 0;
  int n_fail = 0;
  int lat;

`ifdef FOOD_SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    body_x <= mem_x[body_rd_idx];
    body_y <= mem_y[body_rd_idx];
  end

  food_placer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rand_x      (rand_x),
    .rand_y      (rand_y),
    .restart     (restart),
    .move_tick   (move_tick),
    .head_x      (head_x),
    .head_y      (head_y),
    .snake_len   (snake_len),
    .body_rd_idx (body_rd_idx),
    .body_x      (body_x),
    .body_y      (body_y),
    .food_x      (food_x),
    .food_y      (food_y),
    .food_valid  (food_valid),
    .eat         (eat),
    .place_fail  (place_fail),
    .score       (score)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!food_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_body(input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input logic [9:0] x2, input logic [9:0] y2);
    mem_x[0] = x0; mem_y[0] = y0;
    mem_x[1] = x1; mem_y[1] = y1;
    mem_x[2] = x2; mem_y[2] = y2;
  endtask

  task automatic do_eat(input logic [9:0] hx, input logic [9:0] hy);
    move_tick = 1'b1;
    head_x = hx;
    head_y = hy;
    tick(1);
    move_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_x[i] = 10'd0;
      mem_y[i] = 10'd0;
    end
    set_body(10'd100, 10'd100, 10'd90, 10'd100, 10'd80, 10'd100);
    rst_n = 1'b0;
    rand_x = 10'd200;
    rand_y = 10'd300;
    restart = 1'b0;
    move_tick = 1'b0;
    head_x = 10'd0;
    head_y = 10'd0;
    snake_len = 6'd3;
    tick(3);
    chk("rst_food_x", food_x, 320);
    chk("rst_food_y", food_y, 240);
    chk("rst_valid", food_valid, 0);
    chk("rst_eat", eat, 0);
    chk("rst_pfail", place_fail, 0);
    chk("rst_idx", body_rd_idx, 0);
    chk("rst_score", score, 0);
    rst_n = 1'b1;

    // first placement: cycle 1 SAMPLE, SCAN 2..4, valid at 7
    tick(3);
    chk("scan_idx2", body_rd_idx, 2);
    tick(2);
    chk("valid_c6", food_valid, 0);
    tick(1);
    chk("valid_c7", food_valid, 1);
    chk("p1_x", food_x, 200);
    chk("p1_y", food_y, 300);
    chk("p1_pfail", place_fail, 0);

    // head next to food: no eat
    do_eat(10'd200, 10'd301);
    chk("miss_eat", eat, 0);
    chk("miss_valid", food_valid, 1);

    // eat, next candidate collides with segment 0
    rand_x = 10'd100;
    rand_y = 10'd100;
    do_eat(10'd200, 10'd300);
    chk("eat1", eat, 1);
    chk("eat1_valid", food_valid, 0);
    chk("eat1_score", score, SC ? 1 : 0);
    tick(1);
    chk("eat1_pulse", eat, 0);
    rand_x = 10'd300;
    rand_y = 10'd200;
    wait_valid(100, lat);
    chk("coll_lat", lat, 8);
    chk("coll_x", food_x, 300);
    chk("coll_y", food_y, 200);
    chk("coll_pfail", place_fail, 0);

    // body matches every candidate: 8 rejections, forced commit
    rand_x = 10'd150;
    rand_y = 10'd150;
    set_body(10'd150, 10'd150, 10'd150, 10'd150, 10'd150, 10'd150);
    do_eat(10'd300, 10'd200);
    chk("eat2", eat, 1);
    chk("eat2_score", score, SC ? 2 : 0);
    wait_valid(200, lat);
    chk("force_lat", lat, 25);
    chk("force_pfail", place_fail, 1);
    chk("force_x", food_x, 150);
    chk("force_y", food_y, 150);
    tick(1);
    chk("force_pulse", place_fail, 0);

    // out-of-field candidate: 8 range rejections, clamped commit
    rand_x = 10'd0;
    rand_y = 10'd700;
    do_eat(10'd150, 10'd150);
    chk("eat3_score", score, SC ? 3 : 0);
    wait_valid(200, lat);
    chk("range_lat", lat, 9);
    chk("range_x", food_x, 20);
    chk("range_y", food_y, 460);
    chk("range_pfail", place_fail, 1);

    // corner candidate legal, zero-length snake commits directly
    rand_x = 10'd620;
    rand_y = 10'd20;
    snake_len = 6'd0;
    do_eat(10'd20, 10'd460);
    chk("eat4_score", score, SC ? 4 : 0);
    wait_valid(100, lat);
    chk("len0_lat", lat, 2);
    chk("len0_x", food_x, 620);
    chk("len0_y", food_y, 20);
    chk("len0_pfail", place_fail, 0);

    // restart mid-scan with score 5, head on old food
    rand_x = 10'd400;
    rand_y = 10'd400;
    snake_len = 6'd3;
    set_body(10'd100, 10'd100, 10'd90, 10'd100, 10'd80, 10'd100);
    do_eat(10'd620, 10'd20);
    chk("eat5_score", score, SC ? 5 : 0);
    tick(2);
    restart = 1'b1;
    move_tick = 1'b1;
    head_x = 10'd620;
    head_y = 10'd20;
    tick(1);
    restart = 1'b0;
    move_tick = 1'b0;
    chk("rs_eat", eat, 0);
    chk("rs_valid", food_valid, 0);
    chk("rs_score", score, 0);
    wait_valid(100, lat);
    chk("rs_lat", lat, 6);
    chk("rs_x", food_x, 400);

    // restart together with an eat match: restart wins
    restart = 1'b1;
    do_eat(10'd400, 10'd400);
    restart = 1'b0;
    chk("rse_eat", eat, 0);
    chk("rse_valid", food_valid, 0);
    chk("rse_score", score, 0);
    wait_valid(100, lat);
    chk("rse_lat", lat, 6);
    chk("rse_y", food_y, 400);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
